bus_cycle_ctrl: RTL and testbench
=================================

Name: bus_cycle_ctrl

Overview:
Processor-side bus cycle generator that sits directly upstream of the memory/IO responder.
- Accepts single read/write requests from the execution unit over a valid/ready handshake.
- Converts each request into a multiplexed T1/T2/T3/(Tw)/T4 bus cycle driving ALE, CS, RD, WR, IO_M, Address and AD.
- Returns read data, or a timeout indication, on a one-cycle response strobe.

Parameters:
ADDR_W, 20, bus address width
DATA_W, 8, data bus width
MAX_WAIT, 15, maximum Tw cycles before the cycle is aborted (must be >= 1)

Ports:
clk  input  1  clock
rst  input  1  reset (synchronous, active-high)
req_valid  input  1  request present
req_ready  output  1  request accepted on the edge where both valid and ready are high
req_write  input  1  1 = write, 0 = read
req_io  input  1  1 = IO space, 0 = memory
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle completion strobe
rsp_rdata  output  DATA_W  read data; holds until the next read completes
rsp_timeout  output  1  cycle aborted; qualified by rsp_valid
Address  output  ADDR_W  bus address
CS  output  1  bus cycle active, active-high
ALE  output  1  address latch enable, active-high
RD  output  1  read strobe, active-low
WR  output  1  write strobe, active-low
IO_M  output  1  1 = IO cycle, 0 = memory cycle
AD_out  output  DATA_W  multiplexed address/data out
AD_oe  output  1  AD_out drive enable
AD_in  input  DATA_W  read data from bus
READY  input  1  responder ready, sampled in T3 and Tw

Behaviour:
- Reset:
  - State = IDLE.
  - ALE = 0, CS = 0, RD = 1, WR = 1, IO_M = 0, Address = 0, AD_oe = 0, AD_out = 0.
  - rsp_valid = 0, rsp_timeout = 0, rsp_rdata = 0.
  - req_ready = 0 while rst is high.
- States: IDLE, T1, T2, T3, TW, T4, encoded one-hot. Bus outputs are Moore-decoded from the state register plus the captured request registers.
- Request capture: req_ready = 1 in IDLE and T4 only. On accept, addr, write, io and wdata are registered and the next state is T1. With no accept, IDLE stays IDLE and T4 goes to IDLE.
- T1:
  - ALE = 1, CS = 1.
  - Address = captured addr, IO_M = captured io.
  - AD_oe = 1, AD_out = addr[DATA_W-1:0].
  - wait_cnt cleared. Next state T2.
- T2:
  - ALE = 0, CS = 1.
  - Read cycle: RD = 0, AD_oe = 0.
  - Write cycle: WR = 0, AD_oe = 1, AD_out = wdata.
  - Next state T3.
- T3: outputs as in T2.
  - READY = 1: next state T4; a read captures AD_in into rsp_rdata on this edge.
  - READY = 0: next state TW.
- TW: outputs as in T2.
  - READY = 1: next state T4, with read capture as in T3.
  - READY = 0 and wait_cnt == MAX_WAIT-1: next state T4 with timeout flag set; a read loads rsp_rdata with all ones.
  - Otherwise wait_cnt increments and the state stays TW.
  - Result: at most MAX_WAIT TW cycles per bus cycle.
- T4:
  - RD = 1, WR = 1, ALE = 0, CS = 1, AD_oe = 0.
  - rsp_valid = 1 for exactly this cycle; rsp_timeout = timeout flag.
  - A write completion leaves rsp_rdata unchanged.
- Latency: accept at edge k gives T1 in cycle k+1 and T4/rsp_valid in cycle k+4 with zero waits, plus one cycle per TW.
- Back-to-back: a request accepted in T4 starts T1 in the next cycle; there is no IDLE bubble.
- Reset during a cycle:
  - The next edge forces IDLE and deasserts strobes, CS and AD_oe.
  - No rsp_valid is produced; the captured request is discarded.
- Request inputs are ignored outside the accept edge. Changing req_addr mid-cycle has no effect.
- wait_cnt width = $clog2(MAX_WAIT+1).

Decomposition:
- Shared package bus_pkg holds:
  - the bus state enum (one-hot, 6 bits);
  - the ADDR_W/DATA_W defaults;
  - strobe-level constants (STROBE_ON = 0, STROBE_OFF = 1).
- One sub-module, bus_wait_timer, holds the clear/increment wait counter with a terminal-count output (MAX_WAIT-1).

Test Plan:
- Zero-wait read: req addr 0x12345, io = 0, READY = 1 → T1 shows ALE = 1, Address = 0x12345, AD_out = 0x45. RD = 0 for T2–T3. AD_in = 0xA5 in T3 gives rsp_valid at accept+4 with rsp_rdata = 0xA5, rsp_timeout = 0.
- Zero-wait write: addr 0x00F00, io = 1, wdata 0x3C → IO_M = 1 throughout. WR = 0 with AD_out = 0x3C, AD_oe = 1 in T2–T3. rsp_valid at accept+4; rsp_rdata unchanged.
- Wait states: read with READY low for 3 sampled cycles → exactly 3 TW cycles, RD held low, rsp_valid at accept+7.
- Timeout: READY held low, MAX_WAIT = 15 → exactly 15 TW cycles, then T4 with rsp_valid = 1, rsp_timeout = 1, rsp_rdata = 0xFF.
- Back-to-back: second req_valid held during first T4 → accepted in T4, ALE = 1 in the following cycle, no IDLE cycle between.
- Reset in T3 of a read → next cycle IDLE, RD = 1, CS = 0, AD_oe = 0, no rsp_valid. A new request afterwards completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus cycle controller slice.
//   - bus_state_e     : one-hot bus cycle state (IDLE, T1, T2, T3, TW, T4)
//   - ADDR_W_DEF/DATA_W_DEF : default address / data widths
//   - STROBE_ON/OFF   : levels of the active-low RD/WR strobes
//   - in_strobe_phase : true for the states that drive RD/WR (T2, T3, TW)
package bus_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 8;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_T1   = 6'b000010,
    ST_T2   = 6'b000100,
    ST_T3   = 6'b001000,
    ST_TW   = 6'b010000,
    ST_T4   = 6'b100000
  } bus_state_e;

  function automatic logic in_strobe_phase(input bus_state_e s);
    return (s == ST_T2) || (s == ST_T3) || (s == ST_TW);
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Request/response handshake plus multiplexed bus pins of the bus cycle
// controller.
//   master : controller view (drives req_ready, rsp_*, bus strobes, Address, AD_out)
//   slave  : environment view (execution unit + memory/IO responder)
interface bus_cycle_ctrl_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  // request side
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_io;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  // response side
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  // bus side
  logic [ADDR_W-1:0] Address;
  logic              CS;
  logic              ALE;
  logic              RD;
  logic              WR;
  logic              IO_M;
  logic [DATA_W-1:0] AD_out;
  logic              AD_oe;
  logic [DATA_W-1:0] AD_in;
  logic              READY;

  modport master (
    input  req_valid, req_write, req_io, req_addr, req_wdata, AD_in, READY,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           Address, CS, ALE, RD, WR, IO_M, AD_out, AD_oe
  );

  modport slave (
    output req_valid, req_write, req_io, req_addr, req_wdata, AD_in, READY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           Address, CS, ALE, RD, WR, IO_M, AD_out, AD_oe
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Wait-state counter for the bus cycle controller.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : clear counter to zero (takes priority)
//   i_inc    : increment counter
//   o_tc     : terminal count, high while the counter equals MAX_WAIT-1
module bus_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Processor-side bus cycle generator. Turns one accepted read/write request
// into a multiplexed T1/T2/T3/(TW)/T4 bus cycle and reports completion
// (read data or timeout) with a one-cycle rsp_valid strobe in T4.
//   clk, rst : clock, synchronous active-high reset
//   bif      : bus_cycle_ctrl_if.master (request, response and bus pins)
// Strobe outputs are registered from the next state, so they change on the
// same edge as the state register and are glitch-free.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  bus_cycle_ctrl_if.master bif
);

  bus_state_e r_state;
  bus_state_e w_state_next;

  logic              r_write;
  logic              r_io;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              r_ale;
  logic              r_cs;
  logic              r_rd;
  logic              r_wr;
  logic              r_ad_oe;
  logic [DATA_W-1:0] r_ad_out;
  logic              r_rsp_valid;
  logic              r_rsp_timeout;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic w_req_ready;
  logic w_accept;
  logic w_data_done;
  logic w_timeout_hit;
  logic w_wait_tc;
  logic w_wait_clr;
  logic w_wait_inc;
  logic w_strobe_next;

  assign w_req_ready   = !rst && ((r_state == ST_IDLE) || (r_state == ST_T4));
  assign w_accept      = bif.req_valid && w_req_ready;
  assign w_data_done   = ((r_state == ST_T3) || (r_state == ST_TW)) && bif.READY;
  // Abort only from the last permitted wait state.
  assign w_timeout_hit = (r_state == ST_TW) && !bif.READY && w_wait_tc;
  assign w_wait_clr    = (r_state == ST_T1);
  assign w_wait_inc    = (r_state == ST_TW) && !bif.READY && !w_wait_tc;
  assign w_strobe_next = in_strobe_phase(w_state_next);

  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_wait_clr),
    .i_inc (w_wait_inc),
    .o_tc  (w_wait_tc)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_T1;
      ST_T1:   w_state_next = ST_T2;
      ST_T2:   w_state_next = ST_T3;
      ST_T3:   w_state_next = bif.READY ? ST_T4 : ST_TW;
      ST_TW:   if (bif.READY || w_wait_tc) w_state_next = ST_T4;
      ST_T4:   w_state_next = w_accept ? ST_T1 : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_write       <= 1'b0;
      r_io          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_ale         <= 1'b0;
      r_cs          <= 1'b0;
      r_rd          <= STROBE_OFF;
      r_wr          <= STROBE_OFF;
      r_ad_oe       <= 1'b0;
      r_ad_out      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_write <= bif.req_write;
        r_io    <= bif.req_io;
        r_addr  <= bif.req_addr;
        r_wdata <= bif.req_wdata;
      end

      // T1 is only ever entered on an accept edge, so the address phase
      // takes its low byte straight from the request being captured.
      r_ale   <= (w_state_next == ST_T1);
      r_cs    <= (w_state_next != ST_IDLE);
      r_rd    <= (w_strobe_next && !r_write) ? STROBE_ON : STROBE_OFF;
      r_wr    <= (w_strobe_next &&  r_write) ? STROBE_ON : STROBE_OFF;
      r_ad_oe <= (w_state_next == ST_T1) || (w_strobe_next && r_write);
      if (w_state_next == ST_T1) begin
        r_ad_out <= bif.req_addr[DATA_W-1:0];
      end else if (w_strobe_next && r_write) begin
        r_ad_out <= r_wdata;
      end else begin
        r_ad_out <= '0;
      end

      r_rsp_valid   <= (w_state_next == ST_T4);
      r_rsp_timeout <= w_timeout_hit;

      if (!r_write) begin
        if (w_data_done) begin
          r_rsp_rdata <= bif.AD_in;
        end else if (w_timeout_hit) begin
          r_rsp_rdata <= '1;
        end
      end
    end
  end

  assign bif.req_ready   = w_req_ready;
  assign bif.rsp_valid   = r_rsp_valid;
  assign bif.rsp_timeout = r_rsp_timeout;
  assign bif.rsp_rdata   = r_rsp_rdata;
  assign bif.Address     = r_addr;
  assign bif.IO_M        = r_io;
  assign bif.CS          = r_cs;
  assign bif.ALE         = r_ale;
  assign bif.RD          = r_rd;
  assign bif.WR          = r_wr;
  assign bif.AD_oe       = r_ad_oe;
  assign bif.AD_out      = r_ad_out;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed transactions with literal
// expectations, plus a transaction-age model checked every cycle.
module tb_bus_cycle_ctrl;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 15;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  bus_cycle_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  bus_cycle_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model: a transaction is described by its age in cycles since accept
  // (1 = address phase, 2.. = strobe phase, READY sampled from age 3) and
  // a done flag for the completion cycle.
  // ---------------------------------------------------------------------
  int          m_age  = 0;
  bit          m_done = 0;
  bit          m_to   = 0;
  logic [7:0]  m_rdata = 8'h00;
  logic        m_write = 0;
  logic        m_io = 0;
  logic [19:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (m_age == 0) begin
        chk("idle_cs", bif.CS, 0);
        chk("idle_ale", bif.ALE, 0);
        chk("idle_rd", bif.RD, 1);
        chk("idle_wr", bif.WR, 1);
        chk("idle_oe", bif.AD_oe, 0);
        chk("idle_rspv", bif.rsp_valid, 0);
      end else begin
        chk("cyc_addr", bif.Address, m_addr);
        chk("cyc_iom", bif.IO_M, m_io);
        chk("cyc_cs", bif.CS, 1);
        if (m_done) begin
          chk("end_ale", bif.ALE, 0);
          chk("end_rd", bif.RD, 1);
          chk("end_wr", bif.WR, 1);
          chk("end_oe", bif.AD_oe, 0);
          chk("end_rspv", bif.rsp_valid, 1);
          chk("end_to", bif.rsp_timeout, m_to);
        end else if (m_age == 1) begin
          chk("a_ale", bif.ALE, 1);
          chk("a_rd", bif.RD, 1);
          chk("a_wr", bif.WR, 1);
          chk("a_oe", bif.AD_oe, 1);
          chk("a_adout", bif.AD_out, m_addr[7:0]);
          chk("a_rspv", bif.rsp_valid, 0);
        end else begin
          chk("d_ale", bif.ALE, 0);
          chk("d_rd", bif.RD, m_write ? 1 : 0);
          chk("d_wr", bif.WR, m_write ? 0 : 1);
          chk("d_oe", bif.AD_oe, m_write);
          if (m_write) chk("d_adout", bif.AD_out, m_wdata);
          chk("d_rspv", bif.rsp_valid, 0);
        end
      end
      chk("ready", bif.req_ready, (!rst && (m_age == 0 || m_done)) ? 1 : 0);
      chk("rdata", bif.rsp_rdata, m_rdata);

      // advance the model across the coming edge
      if (rst) begin
        m_age = 0; m_done = 0; m_rdata = 8'h00;
      end else if (m_age == 0 || m_done) begin
        m_done = 0;
        if (bif.req_valid) begin
          m_age = 1;
          m_write = bif.req_write; m_io = bif.req_io;
          m_addr = bif.req_addr;   m_wdata = bif.req_wdata;
        end else begin
          m_age = 0;
        end
      end else if (m_age >= 3 && bif.READY) begin
        m_done = 1; m_to = 0;
        if (!m_write) m_rdata = bif.AD_in;
      end else if (m_age == 3 + MAX_WAIT) begin
        m_done = 1; m_to = 1;
        if (!m_write) m_rdata = 8'hFF;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  task automatic issue(input logic w, input logic io, input logic [19:0] addr, input logic [7:0] wd);
    bif.req_valid = 1'b1;
    bif.req_write = w;
    bif.req_io    = io;
    bif.req_addr  = addr;
    bif.req_wdata = wd;
  endtask

  // Waits for the accept edge, holds READY low for nwaits sampled cycles,
  // then checks latency and response against literal expectations.
  task automatic complete(input int nwaits, input logic [7:0] adin, input int exp_lat,
                          input logic [7:0] exp_rdata, input logic exp_to,
                          input logic [19:0] exp_addr);
    int t;
    bit seen;
    t = 1;
    seen = 0;
    @(posedge clk); #2;
    bif.req_valid = 1'b0;
    bif.req_addr  = 20'($urandom);
    bif.req_wdata = 8'($urandom);
    bif.req_io    = 1'($urandom);
    bif.READY     = 1'b0;
    bif.AD_in     = adin;
    @(negedge clk);
    chk("lit_t1_ale", bif.ALE, 1);
    chk("lit_t1_addr", bif.Address, exp_addr);
    chk("lit_t1_adout", bif.AD_out, exp_addr[7:0]);
    while (!seen && t < 40) begin
      @(posedge clk); #2;
      t++;
      bif.READY = (t >= 3 + nwaits);
      @(negedge clk);
      if (bif.rsp_valid) seen = 1;
    end
    chk("lit_latency", seen ? t : 0, exp_lat);
    chk("lit_rdata", bif.rsp_rdata, exp_rdata);
    chk("lit_timeout", bif.rsp_timeout, exp_to);
  endtask

  initial begin
    rst = 1'b1;
    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
    bif.req_io    = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.READY     = 1'b0;
    bif.AD_in     = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_rd", bif.RD, 1);
    chk("lit_rst_wr", bif.WR, 1);
    chk("lit_rst_cs", bif.CS, 0);
    chk("lit_rst_oe", bif.AD_oe, 0);
    chk("lit_rst_ready", bif.req_ready, 0);
    chk("lit_rst_rdata", bif.rsp_rdata, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    // zero-wait memory read
    issue(1'b0, 1'b0, 20'h12345, 8'h00);
    $display("txn read  addr=12345 waits=0");
    complete(0, 8'hA5, 4, 8'hA5, 1'b0, 20'h12345);

    // zero-wait IO write, read data must be left alone
    @(posedge clk); #2;
    issue(1'b1, 1'b1, 20'h00F00, 8'h3C);
    $display("txn write addr=00F00 io=1 data=3C");
    complete(0, 8'hEE, 4, 8'hA5, 1'b0, 20'h00F00);

    // read with three wait states
    @(posedge clk); #2;
    issue(1'b0, 1'b0, 20'h00ABC, 8'h00);
    $display("txn read  addr=00ABC waits=3");
    complete(3, 8'h5A, 7, 8'h5A, 1'b0, 20'h00ABC);

    // read that never gets READY: aborted after MAX_WAIT wait states
    @(posedge clk); #2;
    issue(1'b0, 1'b1, 20'h00001, 8'h00);
    $display("txn read  addr=00001 timeout");
    complete(1000, 8'h11, 4 + MAX_WAIT, 8'hFF, 1'b1, 20'h00001);

    // back-to-back: second request presented during the first T4
    @(posedge clk); #2;
    issue(1'b1, 1'b0, 20'h11111, 8'h99);
    $display("txn write addr=11111 data=99 (b2b first)");
    complete(0, 8'h00, 4, 8'hFF, 1'b0, 20'h11111);
    issue(1'b0, 1'b0, 20'h22222, 8'h00);
    $display("txn read  addr=22222 (b2b second)");
    complete(0, 8'h77, 4, 8'h77, 1'b0, 20'h22222);

    // reset asserted during T3 of a read
    @(posedge clk); #2;
    issue(1'b0, 1'b0, 20'h44444, 8'h00);
    @(posedge clk); #2;
    bif.req_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("lit_abort_rd", bif.RD, 1);
    chk("lit_abort_cs", bif.CS, 0);
    chk("lit_abort_oe", bif.AD_oe, 0);
    chk("lit_abort_rspv", bif.rsp_valid, 0);
    $display("txn read  addr=44444 reset in T3");
    repeat (3) @(posedge clk);
    #2;

    issue(1'b0, 1'b0, 20'h33333, 8'h00);
    $display("txn read  addr=33333 after reset");
    complete(0, 8'h3C, 4, 8'h3C, 1'b0, 20'h33333);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
